ray_dispatcher: RTL and testbench
=================================

# ray_dispatcher

Frame-level scheduler between the ray generator and a bank of NUM_UNITS ray-intersection units. It accepts one ray direction per handshake from the generator and tags it with a sequential pixel index. It hands each ray to the next available unit in round-robin order and tracks rays that are in flight. It pulses frame_done once every pixel of the frame has been issued and retired.

## Interface
- NUM_UNITS, 4, number of downstream intersection units (2..16)
- DIR_W, 32, width of each ray direction component
- IDX_W, 24, width of pixel count and pixel index
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- num_pixels  in  IDX_W  rays in the frame; latched on accepted start
- in_valid  in  1  generator has a ray
- in_ready  out  1  dispatcher accepts a ray this cycle
- in_dir_x, in_dir_y, in_dir_z  in  DIR_W each  ray direction from the generator
- out_valid  out  NUM_UNITS  one-hot offer to unit i
- out_ready  in  NUM_UNITS  unit i can take a ray; must not depend on out_valid
- out_dir_x, out_dir_y, out_dir_z  out  DIR_W each  held ray, broadcast to all units
- out_pixel_idx  out  IDX_W  pixel index of the held ray
- unit_done  in  NUM_UNITS  unit i retired one ray (1-cycle pulse per ray)
- busy  out  1  state != IDLE
- frame_done  out  1  1-cycle pulse at frame completion

## Operation
- States: IDLE, DISPATCH, DRAIN, DONE.
- IDLE:
  - start=1 latches num_pixels and clears load_cnt, outstanding and rr_ptr.
  - Goes to DISPATCH if num_pixels≠0; otherwise goes to DONE.
- Hold register: one entry with hold_valid, dirs and idx. The generator's valid/ready handshake loads it.
- in_ready = (state==DISPATCH) && load_cnt<num_pixels && (!hold_valid || xfer).
- On a load:
  - out_dir_* ← in_dir_*.
  - out_pixel_idx ← load_cnt.
  - load_cnt increments by 1.
  - A load and a transfer in the same cycle replace the register contents, so there are no bubbles.
- Grant selection (combinational):
  - Search starts at rr_ptr and wraps modulo NUM_UNITS.
  - Picks the first i with out_ready[i]=1.
  - out_valid = hold_valid ? onehot(i) : 0.
  - out_valid may depend combinationally on out_ready.
- Transfer (xfer): out_valid[i] && out_ready[i].
  - Clears hold_valid unless a load happens in the same cycle.
  - rr_ptr ← (i+1) mod NUM_UNITS.
  - outstanding increments by 1.
- Retire: outstanding decrements by popcount(unit_done).
  - Net update on a simultaneous xfer and retire: outstanding + xfer − popcount.
  - Saturates at 0; spurious unit_done pulses are ignored.
  - Width is IDX_W+1.
- DISPATCH → DRAIN when load_cnt==num_pixels and hold_valid==0 (the cycle after the last transfer).
- DRAIN → DONE when outstanding==0, evaluated on the registered value.
- DONE → IDLE unconditionally; frame_done = (state==DONE).
- start outside IDLE is ignored.
- num_pixels changes after latching are ignored.
- Mid-frame reset: all state clears, in-flight rays are dropped, and no frame_done is issued.
- Reset values:
  - state=IDLE.
  - in_ready=0, out_valid=0, busy=0, frame_done=0.
  - out_dir_*=0, out_pixel_idx=0.
  - rr_ptr=0, outstanding=0, load_cnt=0.

## Timing
- Cycle T: start accepted. From T+1: busy=1, state=DISPATCH, in_ready=1 if hold is empty.
- A ray loaded at cycle t is offered on out_valid from t+1.
- Issue latency: 1 cycle from input handshake to earliest unit handshake.
- Throughput: 1 ray/cycle while at least one unit is ready every cycle.
- Fairness: with all units ready, grants rotate 0,1,…,NUM_UNITS−1,0,…
- out_dir_* and out_pixel_idx are stable while hold_valid=1 and no xfer occurs.
- Last retire at cycle r brings outstanding to 0 at r+1. frame_done is high at r+2 and busy drops at r+3.
- If the last retire happens before the hold register empties, frame_done follows DRAIN by 1 cycle.
- num_pixels=0: start at T → frame_done at T+1, and no in_ready ever.

## Test plan
- Single frame, num_pixels=8, NUM_UNITS=4, all out_ready=1, unit_done 3 cycles after each grant → grants cycle 0,1,2,3,0,1,2,3, out_pixel_idx 0..7 in order, exactly one frame_done.
- Back-pressure: out_ready=4'b0100 only → every ray goes to unit 2. in_ready=0 whenever hold is full and unit 2 is not ready. No ray lost or duplicated.
- Skip rotation: rr_ptr=1, out_ready=4'b1001 → grant unit 3; next grant, with all ready, is unit 0.
- Simultaneous xfer and unit_done=4'b0011 with outstanding=2 → outstanding becomes 1. Spurious unit_done with outstanding=0 → stays 0.
- num_pixels=0 → frame_done exactly one cycle after start; busy high for 1 cycle.
- reset_n low mid-DISPATCH with 3 rays in flight → all outputs at reset values immediately, no frame_done. A new start with num_pixels=2 runs cleanly from pixel 0.

Source files
------------

// File: rtl/ray_dispatcher.sv
// ray_dispatcher
//
// Frame-level scheduler between the ray generator and NUM_UNITS ray-intersection
// units. Each accepted ray is tagged with a sequential pixel index, parked in a
// one-entry hold register and offered to the first ready unit at or after a
// round-robin pointer. Rays handed to units are counted as outstanding until
// the unit pulses unit_done; once every pixel has been issued and retired the
// block pulses frame_done.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   start, num_pixels      begin a frame of num_pixels rays (sampled in IDLE)
//   in_valid/in_ready      generator handshake, in_dir_{x,y,z} ray direction
//   out_valid/out_ready    per-unit handshake, out_valid is one-hot
//   out_dir_{x,y,z}        held ray broadcast to all units
//   out_pixel_idx          pixel index of the held ray
//   unit_done              per-unit retire pulse, one per ray
//   busy                   frame in progress (state != IDLE)
//   frame_done             one-cycle pulse at frame completion
`timescale 1ns/1ps

module ray_dispatcher #(
  parameter int NUM_UNITS = 4,
  parameter int DIR_W     = 32,
  parameter int IDX_W     = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [IDX_W-1:0]     num_pixels,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIR_W-1:0]     in_dir_x,
  input  logic [DIR_W-1:0]     in_dir_y,
  input  logic [DIR_W-1:0]     in_dir_z,
  output logic [NUM_UNITS-1:0] out_valid,
  input  logic [NUM_UNITS-1:0] out_ready,
  output logic [DIR_W-1:0]     out_dir_x,
  output logic [DIR_W-1:0]     out_dir_y,
  output logic [DIR_W-1:0]     out_dir_z,
  output logic [IDX_W-1:0]     out_pixel_idx,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   num_px;       // frame size latched on start
  logic [IDX_W-1:0]   load_cnt;     // rays accepted so far this frame
  logic [IDX_W:0]     outstanding;  // rays handed to units, not yet retired
  logic [PTR_W-1:0]   rr_ptr;
  logic               hold_valid;

  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic               xfer;
  logic               load;
  logic [IDX_W:0]     done_cnt;
  logic [IDX_W:0]     out_inc;
  logic [IDX_W:0]     outstanding_nxt;
  logic [PTR_W-1:0]   rr_nxt;

  // Round-robin search: first ready unit at or after rr_ptr, wrapping.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    int             cand;
    logic [PTR_W-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_UNITS) cand = cand - NUM_UNITS;
      cand_idx = cand[PTR_W-1:0];
      if (!grant_found && out_ready[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign xfer      = hold_valid && grant_found;
  assign out_valid = xfer ? (NUM_UNITS'(1) << grant_idx) : '0;

  // A transfer in the same cycle frees the hold register, so a new ray can be
  // accepted back-to-back without a bubble.
  assign in_ready = (state == DISPATCH) && (load_cnt < num_px) && (!hold_valid || xfer);
  assign load     = in_valid && in_ready;

  assign rr_nxt = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + PTR_W'(1);

  // Net outstanding update; retire pulses beyond the in-flight count are
  // dropped by saturating at zero.
  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      done_cnt = done_cnt + (IDX_W+1)'(unit_done[i]);
    end
    out_inc         = outstanding + (IDX_W+1)'(xfer);
    outstanding_nxt = (out_inc > done_cnt) ? out_inc - done_cnt : '0;
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      num_px        <= '0;
      load_cnt      <= '0;
      outstanding   <= '0;
      rr_ptr        <= '0;
      hold_valid    <= 1'b0;
      out_dir_x     <= '0;
      out_dir_y     <= '0;
      out_dir_z     <= '0;
      out_pixel_idx <= '0;
    end else begin
      outstanding <= outstanding_nxt;

      if (xfer) rr_ptr <= rr_nxt;

      if (load) begin
        out_dir_x     <= in_dir_x;
        out_dir_y     <= in_dir_y;
        out_dir_z     <= in_dir_z;
        out_pixel_idx <= load_cnt;
        load_cnt      <= load_cnt + IDX_W'(1);
        hold_valid    <= 1'b1;
      end else if (xfer) begin
        hold_valid <= 1'b0;
      end

      // NOTE: the frame-start clears below come later in the block, so they
      // take precedence over the datapath updates above in the same cycle.
      unique case (state)
        IDLE: begin
          if (start) begin
            num_px      <= num_pixels;
            load_cnt    <= '0;
            outstanding <= '0;
            rr_ptr      <= '0;
            hold_valid  <= 1'b0;
            state       <= (num_pixels != '0) ? DISPATCH : DONE;
          end
        end
        DISPATCH: begin
          if ((load_cnt == num_px) && !hold_valid) state <= DRAIN;
        end
        DRAIN: begin
          if (outstanding == '0) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher: random rays and unit readiness,
// a queue of expected rays filled at the input handshake, and a monitor that
// predicts grants, in_ready, busy and frame_done from frame-level rules.
`timescale 1ns/1ps

module tb_ray_dispatcher;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 24;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] num_pixels = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_dir_x = '0, in_dir_y = '0, in_dir_z = '0;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready = '0;
  logic [DW-1:0] out_dir_x, out_dir_y, out_dir_z;
  logic [IW-1:0] out_pixel_idx;
  logic [N-1:0]  unit_done = '0;
  logic          busy;
  logic          frame_done;

  ray_dispatcher #(.NUM_UNITS(N), .DIR_W(DW), .IDX_W(IW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .num_pixels   (num_pixels),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dir_x     (in_dir_x),
    .in_dir_y     (in_dir_y),
    .in_dir_z     (in_dir_z),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_dir_x    (out_dir_x),
    .out_dir_y    (out_dir_y),
    .out_dir_z    (out_dir_z),
    .out_pixel_idx(out_pixel_idx),
    .unit_done    (unit_done),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] z;
    logic [IW-1:0] idx;
  } ray_t;

  ray_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           mode = 0;       // 0 all ready, 1 unit 2 only, 2 random, 3 skip pattern
  bit           hold_off = 1'b0;
  logic [N-1:0] spur = '0;
  logic [N-1:0] sched[16];
  int           gen_cnt = 0;

  // Reference model of the frame
  bit m_active = 1'b0;
  bit m_hold = 1'b0;
  int m_num = 0, m_loads = 0, m_rr = 0, m_grants = 0, m_out = 0, m_done_at = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Input driver: rays, unit readiness and scheduled retire pulses.
  always @(posedge clk) begin
    logic [3:0] slot;
    #1;
    slot = cyc[3:0];
    if (!reset_n) begin
      unit_done = '0;
      for (int i = 0; i < 16; i++) sched[i] = '0;
    end else begin
      unit_done   = sched[slot] | spur;
      sched[slot] = '0;
    end
    in_dir_x = $urandom;
    in_dir_y = $urandom;
    in_dir_z = $urandom;
    in_valid = (mode == 0 || mode == 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
    case (mode)
      0:       out_ready = '1;
      1:       out_ready = hold_off ? 4'b0000 : (($urandom_range(0, 1) != 0) ? 4'b0100 : 4'b0000);
      3:       out_ready = (m_grants == 1) ? 4'b1001 : 4'b1111;
      default: out_ready = N'($urandom);
    endcase
  end

  // Stimulus side of the scoreboard: every accepted ray is expected later.
  always @(negedge clk) begin
    ray_t r;
    if (reset_n && in_valid && in_ready) begin
      r.x   = in_dir_x;
      r.y   = in_dir_y;
      r.z   = in_dir_z;
      r.idx = IW'(gen_cnt);
      exp_q.push_back(r);
      gen_cnt++;
    end
  end

  // Monitor: predicts handshakes and frame status, pops expected rays on grant.
  always @(negedge clk) begin
    logic [N-1:0] exp_ov;
    logic [1:0]   ui;
    logic [3:0]   slot;
    int           g;
    bit           xfer, exp_ir;
    ray_t         r;
    if (!reset_n) begin
      m_active = 1'b0; m_hold = 1'b0; m_num = 0; m_loads = 0;
      m_rr = 0; m_grants = 0; m_out = 0; m_done_at = -1;
    end else begin
      check("busy", 64'(busy), 64'(m_active));
      check("frame_done", 64'(frame_done), 64'(m_active && cyc == m_done_at));

      g = -1;
      if (m_hold) begin
        for (int k = 0; k < N; k++) begin
          ui = 2'((m_rr + k) % N);
          if (g < 0 && out_ready[ui]) g = int'(ui);
        end
      end
      xfer   = (g >= 0);
      exp_ov = xfer ? (N'(1) << g) : '0;
      check("out_valid", 64'(out_valid), 64'(exp_ov));

      exp_ir = m_active && (m_loads < m_num) && (!m_hold || xfer);
      check("in_ready", 64'(in_ready), 64'(exp_ir));

      if (xfer) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ray", 64'(1), 64'(0));
        end else begin
          r = exp_q.pop_front();
          check("out_dir_x", 64'(out_dir_x), 64'(r.x));
          check("out_dir_y", 64'(out_dir_y), 64'(r.y));
          check("out_dir_z", 64'(out_dir_z), 64'(r.z));
          check("out_pixel_idx", 64'(out_pixel_idx), 64'(r.idx));
        end
        if (mode == 0) check("rr_order", 64'(g), 64'(m_grants % N));
        if (mode == 3 && m_grants == 1) check("skip_grant", 64'(g), 64'(3));
        if (mode == 3 && m_grants == 2) check("skip_wrap", 64'(g), 64'(0));
        slot        = 4'(cyc + 3);
        sched[slot] = sched[slot] | exp_ov;
        m_rr        = (g + 1) % N;
        m_grants++;
      end

      m_out = m_out + (xfer ? 1 : 0) - $countones(unit_done);
      if (m_out < 0) m_out = 0;
      if (m_active && m_num != 0 && m_grants == m_num && m_out == 0 && m_done_at < 0)
        m_done_at = cyc + 2;

      if (in_valid && in_ready) begin
        m_loads++;
        m_hold = 1'b1;
      end else if (xfer) begin
        m_hold = 1'b0;
      end

      if (m_active && cyc == m_done_at) begin
        m_active = 1'b0;
      end else if (!m_active && start) begin
        m_active  = 1'b1;
        m_num     = int'(num_pixels);
        m_loads   = 0;
        m_hold    = 1'b0;
        m_rr      = 0;
        m_grants  = 0;
        m_out     = 0;
        m_done_at = (num_pixels == '0) ? cyc + 1 : -1;
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    check({tag, "_out_dir"}, 64'(out_dir_x | out_dir_y | out_dir_z), 64'(0));
    check({tag, "_out_pixel_idx"}, 64'(out_pixel_idx), 64'(0));
  endtask

  task automatic begin_frame(input int md, input int n);
    @(posedge clk);
    #2;
    mode       = md;
    gen_cnt    = 0;
    start      = 1'b1;
    num_pixels = IW'(n);
    @(posedge clk);
    #2;
    start      = 1'b0;
    num_pixels = IW'($urandom);
  endtask

  task automatic wait_done(input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    check("frame_completed", 64'(seen), 64'(1));
    check("rays_left", 64'(exp_q.size()), 64'(0));
    check("grant_count", 64'(m_grants), 64'(n));
  endtask

  initial begin
    #1;
    reset_checks("por");
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full throughput, strict rotation
    begin_frame(0, 8);
    wait_done(8);

    // Empty frame
    begin_frame(0, 0);
    wait_done(0);

    // Only unit 2 ever ready, spurious retire while nothing is in flight,
    // and a start pulse mid-frame that must be ignored
    hold_off = 1'b1;
    begin_frame(1, 10);
    @(negedge clk) spur = '1;
    @(negedge clk) spur = '0;
    @(posedge clk);
    #2 start = 1'b1; num_pixels = IW'(5);
    @(posedge clk);
    #2 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 hold_off = 1'b0;
    wait_done(10);

    // Rotation skipping non-ready units
    begin_frame(3, 4);
    wait_done(4);

    // Random readiness and generator gaps
    begin_frame(2, 40);
    wait_done(40);
    begin_frame(2, 25);
    wait_done(25);

    // Reset in the middle of a frame with rays in flight
    begin_frame(0, 20);
    for (int i = 0; i < 100 && m_grants < 3; i++) @(negedge clk);
    check("rays_in_flight", 64'(m_grants >= 3), 64'(1));
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    reset_checks("midrst");
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    begin_frame(0, 2);
    wait_done(2);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
